// File: rtl/sram_ctrl.sv
// sram_ctrl: multi-cycle data-memory controller for the Mem stage.
// Each 32-bit CPU access is split into two 16-bit SRAM accesses (low half,
// then high half). Each half is held on the bus for SRAM_WAIT_CYCLES cycles.
// `ready` stays low while an access is in flight so the pipeline can freeze.
// Optional feature: define SRAM_ACCESS_COUNT_EN to add the rd_count/wr_count
// saturating access counters.

module sram_ctrl #(
    parameter int          SRAM_WAIT_CYCLES = 5,
    parameter logic [31:0] MEM_BASE_ADDR    = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_out,
    input  logic [15:0] sram_dq_in,
    output logic        sram_dq_oe,
    output logic        sram_we_n
`ifdef SRAM_ACCESS_COUNT_EN
    ,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    // Counter value that keeps a half-access on the bus for SRAM_WAIT_CYCLES.
    localparam logic [3:0] WAIT_LOAD = 4'(SRAM_WAIT_CYCLES - 1);

    // Sequencer state
    state_t      state_reg,   state_next;
    logic [3:0]  count_reg,   count_next;
    logic        is_write_reg, is_write_next;
    logic [16:0] word_reg,    word_next;
    logic [31:0] wdata_reg,   wdata_next;

    // Registered SRAM bus
    logic [17:0] addr_reg,    addr_next;
    logic [15:0] dq_out_reg,  dq_out_next;
    logic        dq_oe_reg,   dq_oe_next;
    logic        we_n_reg,    we_n_next;

    logic        phase_end;
    logic        request;
    logic        bus_active_next;
    logic        high_next;

    // CPU byte address relative to the start of SRAM; wraps modulo 2^32.
    logic [31:0] offset_in;
    logic        addr_unused;

    assign offset_in   = address - MEM_BASE_ADDR;
    // Bits dropped by the half-word address map (byte lane and aliasing bits).
    assign addr_unused = ^{offset_in[31:19], offset_in[1:0]};

    assign request   = rd_en | wr_en;
    assign phase_end = (count_reg == 4'd0);

    // Pipeline handshake: ready when idle with no request, or on the DONE cycle.
    assign ready = (state_reg == DONE) || ((state_reg == IDLE) && !request);

    // Next-state logic: latch the request in IDLE, count down each half-access.
    always_comb begin
        state_next    = state_reg;
        count_next    = count_reg;
        is_write_next = is_write_reg;
        word_next     = word_reg;
        wdata_next    = wdata_reg;
        case (state_reg)
            IDLE: begin
                if (request) begin
                    // A store wins when both enables are raised together.
                    is_write_next = wr_en;
                    word_next     = offset_in[18:2];
                    wdata_next    = write_data;
                    count_next    = WAIT_LOAD;
                    state_next    = LOW;
                end
            end
            LOW: begin
                if (phase_end) begin
                    count_next = WAIT_LOAD;
                    state_next = HIGH;
                end else begin
                    count_next = count_reg - 4'd1;
                end
            end
            HIGH: begin
                if (phase_end) begin
                    state_next = DONE;
                end else begin
                    count_next = count_reg - 4'd1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Bus values for the next cycle, derived from where the sequencer is going.
    // The write strobe is released on the last cycle of each half so the SRAM
    // always sees a rising we_n edge before the address changes.
    always_comb begin
        addr_next       = addr_reg;
        dq_out_next     = dq_out_reg;
        dq_oe_next      = 1'b0;
        we_n_next       = 1'b1;
        bus_active_next = (state_next == LOW) || (state_next == HIGH);
        high_next       = (state_next == HIGH);
        if (bus_active_next) begin
            addr_next = {word_next, high_next};
            if (is_write_next) begin
                dq_out_next = high_next ? wdata_next[31:16] : wdata_next[15:0];
                dq_oe_next  = 1'b1;
                we_n_next   = (count_next == 4'd0);
            end
        end
    end

    // Sequencer registers; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            count_reg    <= 4'd0;
            is_write_reg <= 1'b0;
            word_reg     <= 17'd0;
            wdata_reg    <= 32'd0;
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            is_write_reg <= is_write_next;
            word_reg     <= word_next;
            wdata_reg    <= wdata_next;
        end
    end

    // SRAM bus registers; reset drops the strobe and releases DQ at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_reg   <= 18'd0;
            dq_out_reg <= 16'd0;
            dq_oe_reg  <= 1'b0;
            we_n_reg   <= 1'b1;
        end else begin
            addr_reg   <= addr_next;
            dq_out_reg <= dq_out_next;
            dq_oe_reg  <= dq_oe_next;
            we_n_reg   <= we_n_next;
        end
    end

    assign sram_addr   = addr_reg;
    assign sram_dq_out = dq_out_reg;
    assign sram_dq_oe  = dq_oe_reg;
    assign sram_we_n   = we_n_reg;

    // One capture register per 16-bit half of the load result.
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd_half
        localparam state_t HALF_STATE = (gi == 0) ? LOW : HIGH;
        logic [15:0] half_reg;

        // Capture SRAM data on the final cycle of this half of a load.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                half_reg <= 16'd0;
            end else if ((state_reg == HALF_STATE) && phase_end && !is_write_reg) begin
                half_reg <= sram_dq_in;
            end
        end
    end

    assign read_data = {g_rd_half[1].half_reg, g_rd_half[0].half_reg};

`ifdef SRAM_ACCESS_COUNT_EN
    logic        enter_done;
    logic [15:0] rd_count_reg;
    logic [15:0] wr_count_reg;

    assign enter_done = (state_reg == HIGH) && phase_end;

    // Saturating per-type access counters, bumped as an access reaches DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_count_reg <= 16'd0;
            wr_count_reg <= 16'd0;
        end else if (enter_done) begin
            if (is_write_reg) begin
                if (wr_count_reg != 16'hFFFF) begin
                    wr_count_reg <= wr_count_reg + 16'd1;
                end
            end else begin
                if (rd_count_reg != 16'hFFFF) begin
                    rd_count_reg <= rd_count_reg + 16'd1;
                end
            end
        end
    end

    assign rd_count = rd_count_reg;
    assign wr_count = wr_count_reg;
`endif

    // A one-cycle half never asserts we_n, so stores are unusable at that
    // setting; the wait count must also fit the 4-bit counter.
    a_wait_range: assert property (@(posedge clk) disable iff (!rst)
        (SRAM_WAIT_CYCLES >= 1) && (SRAM_WAIT_CYCLES <= 15));
    a_no_store_single_cycle: assert property (@(posedge clk) disable iff (!rst)
        ((state_reg == IDLE) && wr_en) |-> (SRAM_WAIT_CYCLES > 1));

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: randomized self-checking bench for sram_ctrl.
// A behavioural SRAM sits on the DUT bus; a word-level reference memory
// predicts load results, and a cycle-index timing model predicts the bus.
// Build with SRAM_ACCESS_COUNT_EN defined to also exercise the counters.

module tb_sram_ctrl;

    localparam int          W    = 5;
    localparam logic [31:0] BASE = 32'd1024;
    localparam int          LAT  = 2 * W + 1;
    localparam int          NWORDS = 131072;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] address = 32'd0;
    logic [31:0] write_data = 32'd0;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic [15:0] sram_dq_in;
    logic        sram_dq_oe;
    logic        sram_we_n;
`ifdef SRAM_ACCESS_COUNT_EN
    logic [15:0] rd_count;
    logic [15:0] wr_count;
`endif

    int checks = 0;
    int errors = 0;

    logic [15:0] sram_mem [0:2*NWORDS-1];
    logic [31:0] ref_mem  [0:NWORDS-1];
    logic [31:0] ref_rd = 32'd0;
    int          ref_rd_cnt = 0;
    int          ref_wr_cnt = 0;

    sram_ctrl #(
        .SRAM_WAIT_CYCLES(W),
        .MEM_BASE_ADDR(BASE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rd_en(rd_en),
        .wr_en(wr_en),
        .address(address),
        .write_data(write_data),
        .read_data(read_data),
        .ready(ready),
        .sram_addr(sram_addr),
        .sram_dq_out(sram_dq_out),
        .sram_dq_in(sram_dq_in),
        .sram_dq_oe(sram_dq_oe),
        .sram_we_n(sram_we_n)
`ifdef SRAM_ACCESS_COUNT_EN
        ,
        .rd_count(rd_count),
        .wr_count(wr_count)
`endif
    );

    always #5 clk = ~clk;

    // Asynchronous-read SRAM with a write strobe sampled on the clock edge.
    assign sram_dq_in = sram_mem[sram_addr];
    always @(posedge clk) begin
        if (!sram_we_n) sram_mem[sram_addr] <= sram_dq_out;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // SRAM word index for a CPU byte address: (addr - base)/4, aliased to 17 bits.
    function automatic int word_of(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return int'(off >> 2) % NWORDS;
    endfunction

    function automatic int sat_inc(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    // Runs one access starting now (just after a rising edge, DUT idle) and
    // checks every cycle against the expected timeline. Returns one cycle
    // after DONE, just after the rising edge, with both enables low.
    task automatic run_access(input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [31:0] data, input bit scramble);
        int          w;
        int          c;
        bit          is_wr;
        bit          in_low;
        bit          in_high;
        bit          exp_we;
        logic [16:0] w17;
        w     = word_of(addr);
        w17   = w[16:0];
        is_wr = wr;
        rd_en = rd; wr_en = wr; address = addr; write_data = data;
        c = 0;
        while (1) begin
            @(negedge clk);
            in_low  = (c >= 1) && (c <= W);
            in_high = (c >= W + 1) && (c <= 2 * W);
            check($sformatf("ready c%0d", c), 32'(ready), 32'(c == LAT));
            if (in_low || in_high) begin
                exp_we = is_wr && (c != W) && (c != 2 * W);
                check($sformatf("sram_addr c%0d", c), 32'(sram_addr), 32'({w17, in_high}));
                check($sformatf("dq_oe c%0d", c), 32'(sram_dq_oe), 32'(is_wr));
                check($sformatf("we_n c%0d", c), 32'(sram_we_n), 32'(!exp_we));
                if (is_wr)
                    check($sformatf("dq_out c%0d", c), 32'(sram_dq_out),
                          in_high ? 32'(data[31:16]) : 32'(data[15:0]));
            end else begin
                check($sformatf("we_n_off c%0d", c), 32'(sram_we_n), 32'd1);
                check($sformatf("dq_oe_off c%0d", c), 32'(sram_dq_oe), 32'd0);
            end
            if (ready) break;
            if (c >= LAT + 4) begin
                check("timeout_ready", 32'(ready), 32'd1);
                break;
            end
            @(posedge clk); #1;
            if (scramble) begin
                rd_en = 1'($urandom); wr_en = 1'($urandom);
                address = $urandom; write_data = $urandom;
            end else begin
                rd_en = 1'b0; wr_en = 1'b0;
            end
            c++;
        end
        check("latency", 32'(c), 32'(LAT));
        if (is_wr) ref_mem[w] = data;
        else       ref_rd = ref_mem[w];
        check(is_wr ? "read_data_after_store" : "load_data", read_data, ref_rd);
`ifdef SRAM_ACCESS_COUNT_EN
        if (is_wr) ref_wr_cnt = sat_inc(ref_wr_cnt);
        else       ref_rd_cnt = sat_inc(ref_rd_cnt);
        check("rd_count", 32'(rd_count), 32'(ref_rd_cnt));
        check("wr_count", 32'(wr_count), 32'(ref_wr_cnt));
`endif
        $display("access %s addr=0x%08h data=0x%08h read_data=0x%08h latency=%0d",
                 is_wr ? "ST" : "LD", addr, data, read_data, c);
        @(posedge clk); #1;
        rd_en = 1'b0; wr_en = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        rd_en = 1'b0; wr_en = 1'b0;
        repeat (n) begin
            @(negedge clk);
            check("idle_ready", 32'(ready), 32'd1);
            check("idle_we_n", 32'(sram_we_n), 32'd1);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        int          idx;
        int          kind;
        logic [31:0] abort_addr;

        for (int i = 0; i < NWORDS; i++) begin
            sram_mem[2 * i]     = 16'(i ^ 32'h5A5A);
            sram_mem[2 * i + 1] = 16'(i * 7 + 32'h1111);
            ref_mem[i] = {16'(i * 7 + 32'h1111), 16'(i ^ 32'h5A5A)};
        end

        // Reset and idle outputs
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_we_n", 32'(sram_we_n), 32'd1);
        check("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
        check("rst_read_data", read_data, 32'd0);
        check("rst_sram_addr", 32'(sram_addr), 32'd0);
        check("rst_dq_out", 32'(sram_dq_out), 32'd0);
`ifdef SRAM_ACCESS_COUNT_EN
        check("rst_rd_count", 32'(rd_count), 32'd0);
        check("rst_wr_count", 32'(wr_count), 32'd0);
`endif
        @(posedge clk); #1 rst = 1'b1;
        idle_cycles(2);

        // Directed: store at base, then load from base+4 with known contents
        run_access(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 1'b0);
        sram_mem[2] = 16'h1234;
        sram_mem[3] = 16'hABCD;
        ref_mem[1]  = 32'hABCD1234;
        run_access(1'b1, 1'b0, 32'd1028, 32'h0, 1'b0);
        check("directed_load", read_data, 32'hABCD1234);

        // Both enables: store wins, read_data untouched
        run_access(1'b1, 1'b1, 32'd1032, 32'h0BADF00D, 1'b0);
        run_access(1'b1, 1'b0, 32'd1032, 32'h0, 1'b0);
        check("both_enables_stored", read_data, 32'h0BADF00D);

        // Back-to-back loads with no bubble
        run_access(1'b1, 1'b0, 32'd1024, 32'h0, 1'b0);
        check("b2b_first", read_data, 32'hDEADBEEF);
        run_access(1'b1, 1'b0, 32'd1028, 32'h0, 1'b0);
        check("b2b_second", read_data, 32'hABCD1234);

        // Reset in the middle of the high half of a store
        abort_addr = 32'd1040;
        rd_en = 1'b0; wr_en = 1'b1; address = abort_addr; write_data = 32'h55AA33CC;
        for (int c = 1; c <= W + 3; c++) begin
            @(posedge clk); #1;
            wr_en = 1'b0;
        end
        #2 rst = 1'b0;
        #1;
        check("abort_we_n", 32'(sram_we_n), 32'd1);
        check("abort_dq_oe", 32'(sram_dq_oe), 32'd0);
        check("abort_read_data", read_data, 32'd0);
        check("abort_ready", 32'(ready), 32'd1);
        ref_rd = 32'd0;
        ref_rd_cnt = 0;
        ref_wr_cnt = 0;
        @(posedge clk); #1 rst = 1'b1;
        run_access(1'b1, 1'b0, 32'd1028, 32'h0, 1'b0);
        check("post_abort_load", read_data, 32'hABCD1234);
        run_access(1'b0, 1'b1, abort_addr, 32'h13579BDF, 1'b0);
        run_access(1'b1, 1'b0, abort_addr, 32'h0, 1'b0);

        // Randomized traffic, including aliased and below-base addresses
        for (int i = 0; i < 60; i++) begin
            idx = $urandom_range(0, 15);
            case ($urandom_range(0, 3))
                0, 1:    a = BASE + 32'(4 * idx);
                2:       a = BASE + 32'(4 * idx) + (32'($urandom_range(1, 7)) << 19);
                default: a = BASE - 32'(4 * (idx + 1));
            endcase
            a[1:0] = 2'($urandom_range(0, 3));
            d = $urandom;
            kind = $urandom_range(0, 5);
            run_access(kind <= 2 || kind == 5, kind >= 3, a, d, 1'($urandom));
            idle_cycles($urandom_range(0, 2));
        end

`ifdef SRAM_ACCESS_COUNT_EN
        // Counter saturation
        force dut.rd_count_reg = 16'hFFFF;
        #1 release dut.rd_count_reg;
        ref_rd_cnt = 65535;
        run_access(1'b1, 1'b0, 32'd1024, 32'h0, 1'b0);
        check("rd_count_saturated", 32'(rd_count), 32'h0000FFFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
- Multi-cycle memory controller directly downstream of the Mem stage; replaces its single-cycle data memory.
- Consumes the Mem stage's ALU-result address, store data (val_Rm), mem_read and mem_write.
- Executes each 32-bit access as two 16-bit accesses on an external SRAM.
- Drives `ready` low while busy; the pipeline hazard/freeze logic holds all stages on `~ready`.

Parameters:
- SRAM_WAIT_CYCLES, 5, cycles each 16-bit half-access is held on the SRAM bus (legal 1..15).
- MEM_BASE_ADDR, 1024, CPU byte address that maps to SRAM word 0.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-low; 0 resets the block.
- rd_en  input  1  load request (mem_read from Mem stage).
- wr_en  input  1  store request (mem_write from Mem stage).
- address  input  32  CPU byte address (ALU_res).
- write_data  input  32  store data (val_Rm).
- read_data  output  32  load result.
- ready  output  1  1 means no access is pending or the access completes this cycle.
- sram_addr  output  18  SRAM half-word address.
- sram_dq_out  output  16  SRAM write data.
- sram_dq_in  input  16  SRAM read data.
- sram_dq_oe  output  1  1 means the controller drives the DQ bus.
- sram_we_n  output  1  SRAM write strobe, active-low.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, counter=0, read_data=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_we_n=1. `ready` is then 1 unless a request is present.
- A reset in the middle of an access aborts it. No SRAM write strobe may be left asserted.
- Address map:
  - off = address - MEM_BASE_ADDR (32-bit, wraps modulo 2^32).
  - Low half: sram_addr = {off[18:2],1'b0}. High half: sram_addr = {off[18:2],1'b1}.
  - off[1:0] is ignored; out-of-range addresses alias by truncation.
- States: IDLE, LOW, HIGH, DONE.
- IDLE:
  - No request: ready=1.
  - On (rd_en|wr_en): ready=0 combinationally. Latch op, address and write_data; load counter=SRAM_WAIT_CYCLES-1; go to LOW.
  - wr_en takes priority when both enables are asserted.
- LOW:
  - sram_addr = low half. On a write: sram_dq_out=write_data[15:0], sram_dq_oe=1, sram_we_n=0.
  - Counter decrements each cycle. At counter==0: a read captures sram_dq_in into read_data[15:0]; reload counter; go to HIGH.
- HIGH:
  - Same as LOW using the high half and write_data[31:16]. A read captures into read_data[31:16].
  - At counter==0 go to DONE.
  - sram_we_n returns to 1 for one cycle between LOW and HIGH. Enforce this by deasserting we_n on the last cycle of each write phase.
- DONE: ready=1 for exactly one cycle, then IDLE.
- Latency: request first seen in cycle 0 → ready=1 in cycle 2*SRAM_WAIT_CYCLES+1. Total stall is 2*SRAM_WAIT_CYCLES+1 cycles.
- Request inputs are ignored outside IDLE. A request deasserted mid-access does not cancel it.
- read_data holds its value until the next load overwrites it. Stores do not modify read_data.
- Back-to-back requests: the pipeline advances on DONE. A request present in the following IDLE cycle starts a new access with no extra bubble.
- With SRAM_WAIT_CYCLES=1: each phase lasts 1 cycle and sram_we_n is never asserted on writes. For this reason, SRAM_WAIT_CYCLES=1 is legal only for read-only test configurations; assert in simulation.

Optional Feature:
- Macro: SRAM_ACCESS_COUNT_EN.
- Defined:
  - Adds output ports rd_count[15:0] and wr_count[15:0].
  - Each counter increments on entry to DONE for its access type and saturates at 16'hFFFF.
  - Both clear on reset.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Store 0xDEADBEEF at 1024, SRAM_WAIT_CYCLES=5:
  - sram_addr=0 with dq_out=0xBEEF during cycles 1-5.
  - sram_addr=1 with dq_out=0xDEAD during cycles 6-10.
  - ready=0 in cycles 0-10 and 1 in cycle 11.
  - we_n is low in cycles 1-4 and 6-9, high in cycles 5 and 10.
- Load from 1028 with the SRAM model holding 0x1234 at addr 2 and 0xABCD at addr 3 → read_data=0xABCD1234 while ready=1 in cycle 11.
- rd_en and wr_en asserted together at address 1032 → write performed (we_n pulses at sram_addr 4 and 5); read_data unchanged.
- rst=0 asserted mid-HIGH of a store → immediately state IDLE, we_n=1, dq_oe=0, read_data=0. A new load after release completes normally in 11 cycles.
- Two consecutive loads (1024 then 1028) → second access starts in the cycle after DONE; ready pulses once per access at cycles 11 and 23.
- With SRAM_ACCESS_COUNT_EN: 3 loads and 2 stores → rd_count=3, wr_count=2. Preload the counter to 0xFFFF via force, then one more load → rd_count stays 0xFFFF.
